// File: rtl/jtopl_wrsched.sv
// Operator write scheduler: decodes CPU writes to operator registers and
// times the CSR field/stage strobes against the rotating operator slot.
module jtopl_wrsched #(
  parameter int SLOTS = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       wr,
  input  logic       a0,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       up_mult,
  output logic       up_ksl_tl,
  output logic       up_ar_dr,
  output logic       up_sl_rr,
  output logic       update_op_I,
  output logic       update_op_II,
  output logic       update_op_IV,
  output logic [4:0] slot,
  output logic       zero,
  output logic       busy,
  output logic       drop
);

  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_II, WAIT_IV} state_t;

  localparam logic [4:0] SLOT_MAX = 5'(SLOTS - 1);
  localparam logic [5:0] SLOT_N   = 6'(SLOTS);

  state_t     state_q, state_d;
  logic [4:0] slot_q, slot_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] dout_q, dout_d;
  logic [4:0] tgt_q, tgt_d;
  logic [3:0] grp_q, grp_d;
  logic       drop_q, drop_d;

  logic [3:0] grp_sel;
  logic [4:0] off;
  logic       off_ok;
  logic [4:0] target;
  logic       wr_valid;
  logic [5:0] sum1, sum3;
  logic [4:0] tgt_p1, tgt_p3;

  // Address decode: group from addr[7:5], slot from the 3x6 offset layout.
  always_comb begin
    grp_sel = 4'b0000;
    case (addr_q[7:5])
      3'd1:    grp_sel = 4'b0001;
      3'd2:    grp_sel = 4'b0010;
      3'd3:    grp_sel = 4'b0100;
      3'd4:    grp_sel = 4'b1000;
      default: grp_sel = 4'b0000;
    endcase
  end

  assign off      = addr_q[4:0];
  assign off_ok   = (off[4:3] != 2'd3) && (off[2:0] <= 3'd5);
  assign target   = ({3'b000, off[4:3]} * 5'd6) + {2'b00, off[2:0]};
  assign wr_valid = wr && a0 && (grp_sel != 4'b0000) && off_ok;

  // Later stages see the operator one and three slots after the target.
  assign sum1   = {1'b0, tgt_q} + 6'd1;
  assign sum3   = {1'b0, tgt_q} + 6'd3;
  assign tgt_p1 = (sum1 >= SLOT_N) ? 5'(sum1 - SLOT_N) : sum1[4:0];
  assign tgt_p3 = (sum3 >= SLOT_N) ? 5'(sum3 - SLOT_N) : sum3[4:0];

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    addr_d       = addr_q;
    dout_d       = dout_q;
    tgt_d        = tgt_q;
    grp_d        = grp_q;
    drop_d       = 1'b0;
    update_op_I  = 1'b0;
    update_op_II = 1'b0;
    update_op_IV = 1'b0;

    if (cen) begin
      slot_d = (slot_q == SLOT_MAX) ? 5'd0 : slot_q + 5'd1;
    end
    if (wr && !a0) begin
      addr_d = din;
    end
    // busy is the registered state, so a write landing on the final tick is dropped.
    if (wr_valid && state_q != IDLE) begin
      drop_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (wr_valid) begin
          dout_d  = din;
          tgt_d   = target;
          grp_d   = grp_sel;
          state_d = WAIT_I;
        end
      end
      WAIT_I: begin
        update_op_I = (slot_q == tgt_q);
        if (cen && update_op_I) state_d = WAIT_II;
      end
      WAIT_II: begin
        update_op_II = (slot_q == tgt_p1);
        if (cen && update_op_II) state_d = WAIT_IV;
      end
      WAIT_IV: begin
        update_op_IV = (slot_q == tgt_p3);
        if (cen && update_op_IV) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      slot_q  <= 5'd0;
      addr_q  <= 8'd0;
      dout_q  <= 8'd0;
      tgt_q   <= 5'd0;
      grp_q   <= 4'd0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      tgt_q   <= tgt_d;
      grp_q   <= grp_d;
      drop_q  <= drop_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign up_mult   = busy && grp_q[0];
  assign up_ksl_tl = busy && grp_q[1];
  assign up_ar_dr  = busy && grp_q[2];
  assign up_sl_rr  = busy && grp_q[3];
  assign dout      = dout_q;
  assign slot      = slot_q;
  assign zero      = (slot_q == 5'd0);
  assign drop      = drop_q;

endmodule

// File: tb/tb_jtopl_wrsched.sv
// Bench for jtopl_wrsched: a scoreboard of expected (stage, slot) strobe events
// is filled when a write is accepted and drained by a negedge monitor.
module tb_jtopl_wrsched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b0;
  logic       wr  = 1'b0;
  logic       a0  = 1'b0;
  logic [7:0] din = 8'd0;
  logic [7:0] dout;
  logic       up_mult, up_ksl_tl, up_ar_dr, up_sl_rr;
  logic       update_op_I, update_op_II, update_op_IV;
  logic [4:0] slot;
  logic       zero, busy, drop;

  int errors = 0;
  int checks = 0;

  logic [2:0] q_kind[$];
  logic [4:0] q_slot[$];
  logic [4:0] m_slot = 5'd0;

  jtopl_wrsched #(.SLOTS(18)) dut (
    .clk(clk), .rst(rst), .cen(cen), .wr(wr), .a0(a0), .din(din), .dout(dout),
    .up_mult(up_mult), .up_ksl_tl(up_ksl_tl), .up_ar_dr(up_ar_dr), .up_sl_rr(up_sl_rr),
    .update_op_I(update_op_I), .update_op_II(update_op_II), .update_op_IV(update_op_IV),
    .slot(slot), .zero(zero), .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;

  // Slot tracking and strobe scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    logic [2:0] kind, ek;
    logic [4:0] es;
    checks++;
    if (slot !== m_slot) begin
      errors++;
      $display("FAIL slot_track got=%0d exp=%0d", slot, m_slot);
    end
    kind = {update_op_I, update_op_II, update_op_IV};
    if (cen && !rst && kind != 3'b000) begin
      checks++;
      if (q_kind.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe got=%b slot=%0d exp=none", kind, slot);
      end else begin
        ek = q_kind.pop_front();
        es = q_slot.pop_front();
        if (kind !== ek || slot !== es) begin
          errors++;
          $display("FAIL strobe_event got=%b@%0d exp=%b@%0d", kind, slot, ek, es);
        end
      end
    end
    if (rst) m_slot = 5'd0;
    else if (cen) m_slot = (m_slot == 5'd17) ? 5'd0 : m_slot + 5'd1;
  end

  task automatic step(input logic c);
    cen = c;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic sel, input logic [7:0] d);
    wr = 1'b1; a0 = sel; din = d;
    step(1'b0);
    wr = 1'b0;
  endtask

  task automatic push_events(input int tgt);
    q_kind.push_back(3'b100); q_slot.push_back(5'(tgt));
    q_kind.push_back(3'b010); q_slot.push_back(5'((tgt + 1) % 18));
    q_kind.push_back(3'b001); q_slot.push_back(5'((tgt + 3) % 18));
  endtask

  task automatic goto_slot(input logic [4:0] s);
    int n = 0;
    while (m_slot != s && n < 40) begin step(1'b1); n++; end
    cen = 1'b0;
  endtask

  task automatic run_until_idle(input string name, input logic [3:0] up_exp);
    int n = 0;
    while (busy === 1'b1 && n < 60) begin
      if ({up_sl_rr, up_ar_dr, up_ksl_tl, up_mult} !== up_exp) begin
        errors++;
        $display("FAIL %s_up_held got=%b exp=%b", name, {up_sl_rr, up_ar_dr, up_ksl_tl, up_mult}, up_exp);
      end
      step(1'b1);
      n++;
    end
    cen = 1'b0;
    checks++;
    if (n >= 60 || n > 21) begin
      errors++;
      $display("FAIL %s_busy_span got=%0d exp<=21", name, n);
    end
    checks++;
    if (q_kind.size() != 0) begin
      errors++;
      $display("FAIL %s_events_left got=%0d exp=0", name, q_kind.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b0); step(1'b0);
    rst = 1'b0;
    checks++;
    if ({slot, zero, busy, drop, dout} !== {5'd0, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_state got=%0d/%b/%b/%b/%h exp=0/1/0/0/00", slot, zero, busy, drop, dout);
    end
    checks++;
    if ({update_op_I, update_op_II, update_op_IV, up_mult, up_ksl_tl, up_ar_dr, up_sl_rr} !== 7'd0) begin
      errors++;
      $display("FAIL reset_strobes got=%b exp=0000000",
               {update_op_I, update_op_II, update_op_IV, up_mult, up_ksl_tl, up_ar_dr, up_sl_rr});
    end
  endtask

  task automatic test_idle_count();
    int zeros = 0;
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (zero !== (m_slot == 5'd0) || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_zero_busy got=%b/%b exp=%b/0", zero, busy, m_slot == 5'd0);
      end
      if (zero === 1'b1) zeros++;
      step(1'b1);
    end
    cen = 1'b0;
    checks++;
    if (zeros != 3) begin
      errors++;
      $display("FAIL idle_zero_count got=%0d exp=3", zeros);
    end
  endtask

  task automatic test_mult();
    goto_slot(5'd5);
    bus_write(1'b0, 8'h20);
    push_events(0);
    bus_write(1'b1, 8'hA5);
    checks++;
    if (busy !== 1'b1 || dout !== 8'hA5) begin
      errors++;
      $display("FAIL mult_accept got=%b/%h exp=1/a5", busy, dout);
    end
    run_until_idle("mult", 4'b0001);
  endtask

  task automatic test_wrap();
    bus_write(1'b0, 8'h55);
    push_events(17);
    bus_write(1'b1, 8'h3F);
    checks++;
    if (busy !== 1'b1 || dout !== 8'h3F) begin
      errors++;
      $display("FAIL wrap_accept got=%b/%h exp=1/3f", busy, dout);
    end
    run_until_idle("wrap", 4'b0010);
  endtask

  task automatic test_invalid();
    logic [7:0] addrs[3] = '{8'h26, 8'h3E, 8'hA0};
    for (int k = 0; k < 3; k++) begin
      bus_write(1'b0, addrs[k]);
      bus_write(1'b1, 8'h77);
      checks++;
      if (busy !== 1'b0 || drop !== 1'b0 || dout !== 8'h3F) begin
        errors++;
        $display("FAIL invalid_%h got=%b/%b/%h exp=0/0/3f", addrs[k], busy, drop, dout);
      end
      for (int i = 0; i < 20; i++) step(1'b1);
      cen = 1'b0;
    end
  endtask

  task automatic test_drop_and_back_to_back();
    int n = 0;
    bus_write(1'b0, 8'h41);
    push_events(1);
    bus_write(1'b1, 8'h11);
    bus_write(1'b0, 8'h60);
    bus_write(1'b1, 8'h22);
    checks++;
    if (drop !== 1'b1 || dout !== 8'h11 || up_ksl_tl !== 1'b1 || up_ar_dr !== 1'b0) begin
      errors++;
      $display("FAIL drop_pulse got=%b/%h/%b/%b exp=1/11/1/0", drop, dout, up_ksl_tl, up_ar_dr);
    end
    step(1'b0);
    checks++;
    if (drop !== 1'b0) begin
      errors++;
      $display("FAIL drop_width got=%b exp=0", drop);
    end
    bus_write(1'b0, 8'h84);
    while (update_op_IV !== 1'b1 && n < 60) begin step(1'b1); n++; end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL b2b_wait_iv got=timeout exp=iv");
    end
    wr = 1'b1; a0 = 1'b1; din = 8'h33;
    step(1'b1);
    wr = 1'b0; cen = 1'b0;
    checks++;
    if (busy !== 1'b0 || drop !== 1'b1 || dout !== 8'h11) begin
      errors++;
      $display("FAIL b2b_reject got=%b/%b/%h exp=0/1/11", busy, drop, dout);
    end
    checks++;
    if (q_kind.size() != 0) begin
      errors++;
      $display("FAIL b2b_events_left got=%0d exp=0", q_kind.size());
    end
  endtask

  task automatic test_rst_mid();
    int n = 0;
    bus_write(1'b0, 8'h20);
    push_events(0);
    bus_write(1'b1, 8'h01);
    while (update_op_I !== 1'b1 && n < 60) begin step(1'b1); n++; end
    step(1'b1);
    cen = 1'b0;
    checks++;
    if (update_op_II !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_in_ii got=%b/%b exp=1/1", update_op_II, busy);
    end
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
    q_kind.delete();
    q_slot.delete();
    checks++;
    if ({busy, slot, update_op_I, update_op_II, update_op_IV, up_mult} !== {1'b0, 5'd0, 4'b0000}) begin
      errors++;
      $display("FAIL rstmid_state got=%b/%0d/%b exp=0/0/0000", busy, slot,
               {update_op_I, update_op_II, update_op_IV, up_mult});
    end
    for (int i = 0; i < 40; i++) step(1'b1);
    cen = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_count();
    test_mult();
    test_wrap();
    test_invalid();
    test_drop_and_back_to_back();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtopl_wrsched.md
# jtopl_wrsched

Write scheduler for the operator circular shift register. It accepts CPU bus writes (address/data, OPL-style `a0` port select) and decodes operator registers 0x20–0x95 into a target slot and field group. It then waits for the target slot to rotate through the 18-stage register and drives the `up_*` field selects and `update_op_I/II/IV` stage strobes at the right cen ticks. It sits between the CPU interface and the operator CSR, and also provides the operator slot counter.

## Interface
Parameters:
- `SLOTS`, 18, operator slots per rotation (slot counter wraps `SLOTS-1 → 0`)

Ports:
- `clk`  in  1  system clock; single clock domain
- `rst`  in  1  synchronous, active-high reset
- `cen`  in  1  clock enable; the slot counter and FSM advance only on cen
- `wr`  in  1  CPU write strobe, sampled on every clk (not cen-gated)
- `a0`  in  1  0 = address write, 1 = data write
- `din`  in  8  CPU data bus
- `dout`  out  8  held data for the CSR `din`
- `up_mult`, `up_ksl_tl`, `up_ar_dr`, `up_sl_rr`  out  1 each  field group select, one-hot, level-held while busy
- `update_op_I`, `update_op_II`, `update_op_IV`  out  1 each  stage strobes, valid in the cycle cen is high
- `slot`  out  5  current operator slot, 0..SLOTS-1
- `zero`  out  1  high while `slot==0`
- `busy`  out  1  a write is pending or in flight
- `drop`  out  1  one-clk pulse when a valid data write is rejected because busy

## Operation
- Address latch: `wr & ~a0` loads `addr<=din` in any state. A latch during busy does not affect the in-flight write.
- Decode of a data write (`wr & a0`):
  - group = `addr[7:5]`: 1=mult, 2=ksl_tl, 3=ar_dr, 4=sl_rr; any other value is ignored silently.
  - off = `addr[4:0]`. Invalid if `off[4:3]==3` or `off[2:0]>5`.
  - target = `off[4:3]*6 + off[2:0]`, range 0..17.
- Acceptance: a valid write in IDLE sets `dout<=din`, `tgt<=target`, the one-hot group, and `busy<=1`. A valid write while busy pulses `drop`; dout, tgt and group are unchanged. Invalid or ignored writes have no effect and no drop.
- FSM states: IDLE, WAIT_I, WAIT_II, WAIT_IV.
  - IDLE→WAIT_I on acceptance.
  - WAIT_I: `update_op_I = (slot==tgt)`; on `cen & slot==tgt` → WAIT_II.
  - WAIT_II: `update_op_II = (slot==tgt+1 mod SLOTS)`; on match with cen → WAIT_IV.
  - WAIT_IV: `update_op_IV = (slot==tgt+3 mod SLOTS)`; on match with cen → IDLE, busy cleared.
- Strobes are combinational from registered state, slot and tgt. Every strobe is 0 outside its own state. `up_*` are 0 in IDLE.
- Slot counter: `slot<=(slot==SLOTS-1)?0:slot+1` on cen. It runs freely and independently of the FSM.
- Modular arithmetic: `tgt+1` and `tgt+3` wrap modulo 18. Example: tgt=16 gives II at 17 and IV at 1.
- Reset: slot=0, state IDLE, busy=0, dout=0, addr=0, group=0, drop=0, all strobes 0. Reset mid-write abandons it; no strobe fires.

## Timing
- Acceptance is registered: busy rises the clk after the write.
- A write accepted in the same cycle busy clears is still rejected, because busy is the registered value.
- Latency from acceptance to the update_op_I tick is 1..18 cen ticks (18 when slot==tgt at acceptance, since the state updates after that tick). II comes 1 cen tick after I; IV comes 2 cen ticks after II.
- busy spans at most 21 cen ticks plus 1 clk.
- cen low: no state or slot change; strobes may be high but the CSR ignores them without cen.
- `zero` follows slot combinationally.

## Test plan
- Reset then idle 40 cen → slot counts 0..17 and wraps, zero high once per 18 ticks, all strobes 0, busy 0.
- Write addr 0x20, data 0xA5 at slot 5 → up_mult held, dout=0xA5, update_op_I with cen at slot 0, II at slot 1, IV at slot 3, then busy drops.
- Write addr 0x55 (tgt 17), data 0x3F → up_ksl_tl, I at slot 17, II at slot 0, IV at slot 2 (wrap).
- Writes to addr 0x26, 0x3E, 0xA0 → no busy, no drop, no strobes.
- Second valid data write during busy → one-clk drop pulse, dout unchanged, original write completes; address latch during busy does not alter tgt.
- Assert rst while in WAIT_II → next cycle IDLE, slot=0, no update_op_II or IV ever asserted.
